// File: rtl/uart_mon_pkg.sv
// uart_mon_pkg: shared constants and state type for the UART line monitor.
package uart_mon_pkg;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] KW_PASS [4] = '{8'h50, 8'h41, 8'h53, 8'h53};
    localparam logic [7:0] KW_FAIL [4] = '{8'h46, 8'h41, 8'h49, 8'h4C};
    typedef enum logic {COLLECT, DRAIN} state_e;
endpackage

// File: rtl/uart_line_buf.sv
// uart_line_buf: line storage with one write port and a registered read port.
module uart_line_buf #(
    parameter int LINE_LEN = 80,
    parameter int AW       = $clog2(LINE_LEN)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);
    logic [7:0] mem_q [LINE_LEN];
    logic [7:0] rdata_q;
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end
    // Write-through so a one-byte line can be replayed the cycle after it lands
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rdata_q <= '0;
        else if (re_i) rdata_q <= (we_i && waddr_i == raddr_i) ? wdata_i : mem_q[raddr_i];
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/uart_line_monitor.sv
// uart_line_monitor: assembles UART bytes into lines, replays them to a sink,
// flags PASS/FAIL lines and counts lines and discarded error bytes.
module uart_line_monitor
    import uart_mon_pkg::*;
#(
    parameter int LINE_LEN = 80,
    parameter int CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [7:0]       rx_data_i,
    input  logic             rx_valid_i,
    input  logic             rx_err_i,
    output logic             rx_ready_o,
    output logic [7:0]       out_data_o,
    output logic             out_valid_o,
    output logic             out_last_o,
    input  logic             out_ready_i,
    output logic             pass_o,
    output logic             fail_o,
    output logic             ovf_o,
    output logic [CNT_W-1:0] line_cnt_o,
    output logic [7:0]       err_cnt_o
);
    localparam int PW = $clog2(LINE_LEN + 1);
    localparam int AW = $clog2(LINE_LEN);
    state_e state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, len_q, len_d;
    logic [1:0] match_q, match_d, match_cur;
    logic pass_q, pass_d, fail_q, fail_d, ovf_q, ovf_d, valid_q, valid_d, last_q, last_d;
    logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic accept, store, is_lf, line_end, hs, rd_en;
    logic [AW-1:0] rd_addr;

    assign rx_ready_o = state_q == COLLECT;
    assign accept     = rx_valid_i & rx_ready_o;
    assign store      = accept & ~rx_err_i & (rx_data_i != CHAR_CR);
    assign is_lf      = rx_data_i == CHAR_LF;
    assign line_end   = store & (is_lf | (wr_ptr_q == PW'(LINE_LEN - 1)));
    assign hs         = valid_q & out_ready_i;
    assign rd_en      = line_end | (hs & ~last_q);
    assign rd_addr    = line_end ? '0 : AW'(rd_ptr_q + 1'b1);
    // bit 0 tracks "PASS", bit 1 tracks "FAIL"; only indices 0..3 can disqualify
    assign match_cur  = (wr_ptr_q < PW'(4))
                      ? match_q & ~{rx_data_i != KW_FAIL[wr_ptr_q[1:0]], rx_data_i != KW_PASS[wr_ptr_q[1:0]]}
                      : match_q;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        len_d      = len_q;
        match_d    = match_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        ovf_d      = 1'b0;
        valid_d    = valid_q;
        last_d     = last_q;
        line_cnt_d = line_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (accept && rx_err_i && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 1'b1;
        if (store) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            match_d  = match_cur;
        end
        if (line_end) begin
            state_d  = DRAIN;
            wr_ptr_d = '0;
            len_d    = wr_ptr_q + 1'b1;
            match_d  = 2'b11;
            ovf_d    = ~is_lf;
            valid_d  = 1'b1;
            last_d   = wr_ptr_q == '0;
            if (!(&line_cnt_q)) line_cnt_d = line_cnt_q + 1'b1;
            if (wr_ptr_q >= PW'(3)) begin
                pass_d = pass_q | match_cur[0];
                fail_d = fail_q | match_cur[1];
            end
        end
        if (hs) begin
            if (last_q) begin
                state_d  = COLLECT;
                rd_ptr_d = '0;
                valid_d  = 1'b0;
                last_d   = 1'b0;
            end else begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                last_d   = rd_ptr_q + PW'(2) == len_q;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= COLLECT;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            len_q      <= '0;
            match_q    <= 2'b11;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            line_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            len_q      <= len_d;
            match_q    <= match_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            line_cnt_q <= line_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    uart_line_buf #(.LINE_LEN(LINE_LEN), .AW(AW)) u_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (store),
        .waddr_i (AW'(wr_ptr_q)),
        .wdata_i (rx_data_i),
        .re_i    (rd_en),
        .raddr_i (rd_addr),
        .rdata_o (out_data_o)
    );

    assign out_valid_o = valid_q;
    assign out_last_o  = last_q;
    assign pass_o      = pass_q;
    assign fail_o      = fail_q;
    assign ovf_o       = ovf_q;
    assign line_cnt_o  = line_cnt_q;
    assign err_cnt_o   = err_cnt_q;
endmodule

// File: tb/tb_uart_line_monitor.sv
// tb_uart_line_monitor: directed line vectors against an 80-byte and a 4-byte monitor.
module tb_uart_line_monitor;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] a_rd = '0, b_rd = '0, a_od, b_od, a_ec, b_ec;
    logic a_rv = 1'b0, b_rv = 1'b0, a_re = 1'b0, b_re = 1'b0, a_ordy = 1'b1, b_ordy = 1'b1;
    logic a_rdy, b_rdy, a_ov, b_ov, a_ol, b_ol, a_p, b_p, a_f, b_f, a_ovf, b_ovf;
    logic [15:0] a_lc, b_lc;

    uart_line_monitor #(.LINE_LEN(80), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .rx_data_i(a_rd), .rx_valid_i(a_rv), .rx_err_i(a_re),
        .rx_ready_o(a_rdy), .out_data_o(a_od), .out_valid_o(a_ov), .out_last_o(a_ol),
        .out_ready_i(a_ordy), .pass_o(a_p), .fail_o(a_f), .ovf_o(a_ovf),
        .line_cnt_o(a_lc), .err_cnt_o(a_ec));

    uart_line_monitor #(.LINE_LEN(4), .CNT_W(16)) dut4 (
        .clk_i(clk), .rst_i(rst), .rx_data_i(b_rd), .rx_valid_i(b_rv), .rx_err_i(b_re),
        .rx_ready_o(b_rdy), .out_data_o(b_od), .out_valid_o(b_ov), .out_last_o(b_ol),
        .out_ready_i(b_ordy), .pass_o(b_p), .fail_o(b_f), .ovf_o(b_ovf),
        .line_cnt_o(b_lc), .err_cnt_o(b_ec));

    int checks = 0, errors = 0;
    int a_ovf_n = 0, b_ovf_n = 0, b_busy_rdy = 0;
    logic [8:0] qa[$], qb[$];

    always @(negedge clk) begin
        if (a_ov && a_ordy) qa.push_back({a_ol, a_od});
        if (b_ov && b_ordy) qb.push_back({b_ol, b_od});
        if (a_ovf) a_ovf_n++;
        if (b_ovf) b_ovf_n++;
        if (b_ov && b_rdy) b_busy_rdy++;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic string hexs(input string s);
        string r = "";
        for (int k = 0; k < s.len(); k++) r = $sformatf("%s%02x ", r, s[k]);
        return r;
    endfunction

    task automatic chks(input string nm, input string got, input string exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=[%s] exp=[%s]", nm, hexs(got), hexs(exp));
        end
    endtask

    task automatic send(input bit u, input logic [7:0] b, input logic e);
        int t = 0;
        while (!(u ? b_rdy : a_rdy) && t < 300) begin @(negedge clk); t++; end
        if (t >= 300) chk("send_timeout", 32'(t), 0);
        if (u) begin b_rd = b; b_re = e; b_rv = 1'b1; end
        else begin a_rd = b; a_re = e; a_rv = 1'b1; end
        @(posedge clk); #1;
        a_rv = 1'b0; b_rv = 1'b0; a_re = 1'b0; b_re = 1'b0;
    endtask

    task automatic send_str(input bit u, input string s);
        for (int k = 0; k < s.len(); k++) send(u, s[k], 1'b0);
    endtask

    task automatic wait_out(input bit u, input int n);
        int t = 0;
        while ((u ? qb.size() : qa.size()) < n && t < 500) begin @(negedge clk); t++; end
        if (t >= 500) chk("drain_timeout", 32'(t), 0);
        @(posedge clk); #1;
    endtask

    task automatic pop_all(input bit u, output string d, output string m);
        logic [8:0] v;
        d = ""; m = "";
        while ((u ? qb.size() : qa.size()) > 0) begin
            v = u ? qb.pop_front() : qa.pop_front();
            d = $sformatf("%s%c", d, v[7:0]);
            m = $sformatf("%s%0d", m, v[8]);
        end
    endtask

    typedef struct {
        string tx;
        string rx;
        bit    p;
        bit    f;
        int    lc;
    } row_t;
    row_t rows[6];

    initial begin
        string d, m, em;
        int bad;
        rows[0] = '{"hi\r\n",     "hi\n",     1'b0, 1'b0, 1};
        rows[1] = '{"PAS\n",      "PAS\n",    1'b0, 1'b0, 2};
        rows[2] = '{"xPASS\n",    "xPASS\n",  1'b0, 1'b0, 3};
        rows[3] = '{"\n",         "\n",       1'b0, 1'b0, 4};
        rows[4] = '{"PASS\n",     "PASS\n",   1'b1, 1'b0, 5};
        rows[5] = '{"FAIL ok\n",  "FAIL ok\n",1'b1, 1'b1, 6};

        #2;
        chk("rst_out_valid", 32'(a_ov), 0);
        chk("rst_out_data", 32'(a_od), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rx_ready", 32'(a_rdy), 1);
        chk("rst_flags", {29'd0, a_p, a_f, a_ol}, 0);
        chk("rst_counts", {8'd0, a_ec, a_lc}, 0);

        foreach (rows[i]) begin
            send_str(1'b0, rows[i].tx);
            wait_out(1'b0, rows[i].rx.len());
            pop_all(1'b0, d, m);
            em = "";
            for (int k = 0; k < rows[i].rx.len(); k++) em = $sformatf("%s%0d", em, k == rows[i].rx.len() - 1);
            chks($sformatf("row%0d_data", i), d, rows[i].rx);
            chks($sformatf("row%0d_last", i), m, em);
            chk($sformatf("row%0d_pass", i), 32'(a_p), 32'(rows[i].p));
            chk($sformatf("row%0d_fail", i), 32'(a_f), 32'(rows[i].f));
            chk($sformatf("row%0d_lines", i), 32'(a_lc), 32'(rows[i].lc));
            chk($sformatf("row%0d_ready", i), 32'(a_rdy), 1);
        end
        chk("a_err_cnt_zero", 32'(a_ec), 0);
        chk("a_no_ovf", 32'(a_ovf_n), 0);

        send(1'b0, 8'h41, 1'b1);
        chk("err_one", 32'(a_ec), 1);
        for (int k = 0; k < 300; k++) send(1'b0, 8'(k), 1'b1);
        chk("err_saturate", 32'(a_ec), 255);
        chk("err_lines", 32'(a_lc), 6);
        chk("err_no_output", 32'(qa.size()), 0);
        send_str(1'b0, "Z\n");
        wait_out(1'b0, 2);
        pop_all(1'b0, d, m);
        chks("after_err_data", d, "Z\n");
        chks("after_err_last", m, "01");

        send_str(1'b1, "abcdef\nFAILURE\n");
        wait_out(1'b1, 15);
        pop_all(1'b1, d, m);
        chks("l4_data", d, "abcdef\nFAILURE\n");
        chks("l4_last", m, "000100100010001");
        chk("l4_ovf_pulses", 32'(b_ovf_n), 2);
        chk("l4_lines", 32'(b_lc), 4);
        chk("l4_fail", 32'(b_f), 1);
        chk("l4_pass", 32'(b_p), 0);
        chk("l4_ready_in_drain", 32'(b_busy_rdy), 0);

        a_ordy = 1'b0;
        send_str(1'b0, "ab\n");
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (a_od != 8'h61 || !a_ov || a_ol || a_rdy) bad++;
        end
        chk("stall_hold", 32'(bad), 0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(a_ov), 0);
        @(negedge clk);
        rst = 1'b0;
        a_ordy = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 32'(a_rdy), 1);
        chk("post_rst_state", {13'd0, a_p, a_f, a_ov, a_ec, a_lc}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
